// File: rtl/softmax_div_feeder.sv
// Operand sequencer for the softmax normalising divider: buffers exp values,
// latches their sum, then feeds one divide per entry and forwards quotients in order.
module softmax_div_feeder #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int MIN_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   exp_in,
    input  logic          exp_vld,
    input  logic [31:0]   sum_in,
    input  logic          sum_vld,
    output logic [31:0]   dividend,
    output logic          dividend_strb,
    output logic [31:0]   divisor,
    output logic          divisor_strb,
    input  logic [31:0]   div_z,
    input  logic          div_z_strb,
    output logic          div_z_ack,
    output logic [31:0]   q_out,
    output logic          q_vld,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   count
);

    localparam int LW = $clog2(MIN_LAT + 1);

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   lat_cnt;

    logic            full;
    logic            accept_wr;
    logic [AW:0]     count_next;
    logic            lat_done;
    logic            last_entry;
    logic [AW-1:0]   rd_next;

    assign full       = (count == (AW+1)'(DEPTH));
    assign accept_wr  = (state == LOAD) && exp_vld && !full;
    assign count_next = count + {{AW{1'b0}}, accept_wr};
    assign lat_done   = (lat_cnt == LW'(MIN_LAT));
    assign last_entry = ({1'b0, rd_ptr} == (count - (AW+1)'(1)));
    assign rd_next    = rd_ptr + AW'(1);

    // Buffer storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem[count[AW-1:0]] <= exp_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LOAD;
            rd_ptr        <= '0;
            lat_cnt       <= '0;
            count         <= '0;
            dividend      <= '0;
            dividend_strb <= 1'b0;
            divisor       <= '0;
            divisor_strb  <= 1'b0;
            div_z_ack     <= 1'b0;
            q_out         <= '0;
            q_vld         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            dividend_strb <= 1'b0;
            divisor_strb  <= 1'b0;
            div_z_ack     <= 1'b0;
            q_vld         <= 1'b0;
            done          <= 1'b0;

            case (state)
                LOAD: begin
                    if (accept_wr) begin
                        count <= count_next;
                    end
                    if (exp_vld && full) begin
                        overflow <= 1'b1;
                    end
                    // A write in the same cycle as sum_vld joins the vector; if the
                    // buffer was empty that new entry is the first one issued.
                    if (sum_vld && (count_next != '0)) begin
                        divisor       <= sum_in;
                        dividend      <= (count == '0) ? exp_in : mem[0];
                        dividend_strb <= 1'b1;
                        divisor_strb  <= 1'b1;
                        rd_ptr        <= '0;
                        lat_cnt       <= '0;
                        busy          <= 1'b1;
                        state         <= WAIT;
                    end
                end

                WAIT: begin
                    if (!lat_done) begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                    if (lat_done && div_z_strb) begin
                        q_out     <= div_z;
                        q_vld     <= 1'b1;
                        div_z_ack <= 1'b1;
                        if (last_entry) begin
                            state <= DONE;
                        end else begin
                            rd_ptr        <= rd_next;
                            dividend      <= mem[rd_next];
                            dividend_strb <= 1'b1;
                            divisor_strb  <= 1'b1;
                            lat_cnt       <= '0;
                        end
                    end
                end

                DONE: begin
                    done   <= 1'b1;
                    count  <= '0;
                    rd_ptr <= '0;
                    busy   <= 1'b0;
                    state  <= LOAD;
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_div_feeder.sv
// Randomised bench for softmax_div_feeder with a stub divider that echoes the
// dividend after a programmable delay, checked against a queue-based model.
module tb_softmax_div_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   exp_in = '0;
    logic          exp_vld = 1'b0;
    logic [31:0]   sum_in = '0;
    logic          sum_vld = 1'b0;
    logic [31:0]   dividend;
    logic          dividend_strb;
    logic [31:0]   divisor;
    logic          divisor_strb;
    logic [31:0]   div_z = '0;
    logic          div_z_strb = 1'b0;
    logic          div_z_ack;
    logic [31:0]   q_out;
    logic          q_vld;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   count;

    softmax_div_feeder #(.DEPTH(DEPTH), .AW(AW), .MIN_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .exp_in(exp_in), .exp_vld(exp_vld),
        .sum_in(sum_in), .sum_vld(sum_vld),
        .dividend(dividend), .dividend_strb(dividend_strb),
        .divisor(divisor), .divisor_strb(divisor_strb),
        .div_z(div_z), .div_z_strb(div_z_strb), .div_z_ack(div_z_ack),
        .q_out(q_out), .q_vld(q_vld),
        .busy(busy), .done(done), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub divider: returns the issued dividend stub_lat cycles after the issue,
    // optionally with a bogus early pulse 2 cycles after the issue.
    int unsigned stub_lat = 6;
    bit          spur_en = 1'b0;
    int unsigned tgt = 0;
    int unsigned spur_t = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_val = '0;

    always @(negedge clk) begin
        div_z_strb = 1'b0;
        if (!rst_n) begin
            pend   = 1'b0;
            spur_t = 0;
        end else begin
            if (dividend_strb) begin
                pend     = 1'b1;
                tgt      = cyc + stub_lat;
                spur_t   = cyc + 2;
                pend_val = dividend;
            end
            if (pend && (cyc + 1 == tgt)) begin
                div_z_strb = 1'b1;
                div_z      = pend_val;
                pend       = 1'b0;
            end else if (spur_en && spur_t != 0 && (cyc + 1 == spur_t)) begin
                div_z_strb = 1'b1;
                div_z      = 32'hDEADBEEF;
            end
        end
    end

    // Observation: issues, quotients, done pulses and protocol violations.
    logic [31:0] iss_q[$];
    logic [31:0] dvs_q[$];
    logic [31:0] q_q[$];
    int          done_cnt = 0;
    int          proto_err = 0;
    bit          outstanding = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (q_vld) begin
                q_q.push_back(q_out);
                outstanding = 1'b0;
            end
            if (q_vld !== div_z_ack) proto_err++;
            if (dividend_strb) begin
                if (outstanding) proto_err++;
                outstanding = 1'b1;
                iss_q.push_back(dividend);
                dvs_q.push_back(divisor);
                if (divisor_strb !== 1'b1) proto_err++;
            end else if (divisor_strb) begin
                proto_err++;
            end
            if (done) done_cnt++;
        end else begin
            outstanding = 1'b0;
        end
    end

    function automatic logic [139:0] all_outs();
        return {dividend, dividend_strb, divisor, divisor_strb, div_z_ack,
                q_out, q_vld, busy, done, overflow, count};
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        iss_q.delete();
        dvs_q.delete();
        q_q.delete();
        done_cnt  = 0;
        proto_err = 0;
    endtask

    task automatic write_exp(input logic [31:0] v);
        exp_in  = v;
        exp_vld = 1'b1;
        tick();
        exp_vld = 1'b0;
    endtask

    task automatic send_sum(input logic [31:0] s);
        sum_in  = s;
        sum_vld = 1'b1;
        tick();
        sum_vld = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        total++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h expected 0", all_outs());
        else passed++;
        rst_n = 1'b1;
        tick(2);
        total++;
        if ({busy, count} !== '0) $display("FAIL post_reset_idle: got %h expected 0", {busy, count});
        else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] w[$] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F800000};
        bit ok;
        clear_obs();
        stub_lat = 6;
        foreach (w[i]) write_exp(w[i]);
        total++;
        if (count !== 5'd4) $display("FAIL basic_count: got %0d expected 4", count);
        else passed++;
        send_sum(32'h41000000);
        total++;
        if ({dividend_strb, divisor_strb, busy, dividend, divisor} !== {3'b111, w[0], 32'h41000000})
            $display("FAIL basic_first_issue: got %b%b%b %h %h expected 111 %h 41000000",
                     dividend_strb, divisor_strb, busy, dividend, divisor, w[0]);
        else passed++;
        wait_done(400, ok);
        total++;
        if (!ok) $display("FAIL basic_done_timeout: got done=0 expected done=1");
        else passed++;
        total++;
        if (iss_q.size() != 4 || q_q.size() != 4)
            $display("FAIL basic_counts: got issues=%0d quotients=%0d expected 4/4", iss_q.size(), q_q.size());
        else passed++;
        for (int i = 0; i < 4 && i < iss_q.size() && i < q_q.size(); i++) begin
            total++;
            if (iss_q[i] !== w[i] || dvs_q[i] !== 32'h41000000 || q_q[i] !== w[i])
                $display("FAIL basic_entry%0d: got %h/%h/%h expected %h/41000000/%h",
                         i, iss_q[i], dvs_q[i], q_q[i], w[i], w[i]);
            else passed++;
        end
        tick();
        total++;
        if ({done_cnt, proto_err, busy, count} !== {32'd1, 32'd0, 1'b0, 5'd0})
            $display("FAIL basic_finish: got done=%0d perr=%0d busy=%b count=%0d expected 1 0 0 0",
                     done_cnt, proto_err, busy, count);
        else passed++;
        total++;
        if (divisor !== 32'h41000000) $display("FAIL basic_divisor_hold: got %h expected 41000000", divisor);
        else passed++;
    endtask

    task automatic test_random();
        bit ok;
        for (int v = 0; v < 6; v++) begin
            logic [31:0] w[$];
            logic [31:0] s;
            int n;
            n = $urandom_range(1, DEPTH);
            s = $urandom;
            stub_lat = $urandom_range(5, 9);
            clear_obs();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            foreach (w[i]) write_exp(w[i]);
            send_sum(s);
            wait_done(1000, ok);
            tick();
            total++;
            if (!ok || iss_q.size() != n || q_q.size() != n || done_cnt != 1 || proto_err != 0)
                $display("FAIL random%0d_shape: got ok=%b iss=%0d q=%0d done=%0d perr=%0d expected 1 %0d %0d 1 0",
                         v, ok, iss_q.size(), q_q.size(), done_cnt, proto_err, n, n);
            else passed++;
            total++;
            if (iss_q != w || q_q != w || dvs_q.size() != n || dvs_q.sum() with (int'(item != s)) != 0)
                $display("FAIL random%0d_values: sequence or divisor differs from model (n=%0d sum=%h)", v, n, s);
            else passed++;
        end
        stub_lat = 6;
    endtask

    task automatic test_early_strobe();
        logic [31:0] w[$];
        bit ok;
        clear_obs();
        spur_en = 1'b1;
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        foreach (w[i]) write_exp(w[i]);
        send_sum(32'h40400000);
        wait_done(400, ok);
        spur_en = 1'b0;
        total++;
        if (!ok || q_q != w || proto_err != 0)
            $display("FAIL early_strobe: got ok=%b quotients=%0d perr=%0d expected 1 3 0", ok, q_q.size(), proto_err);
        else passed++;
        tick();
    endtask

    task automatic test_empty_sum();
        clear_obs();
        send_sum(32'h3F800000);
        tick(3);
        total++;
        if (iss_q.size() != 0 || busy !== 1'b0 || count !== '0)
            $display("FAIL empty_sum: got issues=%0d busy=%b count=%0d expected 0 0 0", iss_q.size(), busy, count);
        else passed++;
    endtask

    task automatic test_exp_in_wait();
        logic [31:0] w[$] = '{32'h11111111, 32'h22222222, 32'h33333333};
        bit ok;
        clear_obs();
        foreach (w[i]) write_exp(w[i]);
        send_sum(32'h44444444);
        for (int i = 0; i < 3; i++) write_exp(32'hABCD0000 + i);
        total++;
        if (count !== 5'd3 || overflow !== 1'b0 || busy !== 1'b1)
            $display("FAIL exp_in_wait: got count=%0d ovf=%b busy=%b expected 3 0 1", count, overflow, busy);
        else passed++;
        wait_done(400, ok);
        total++;
        if (!ok || iss_q != w)
            $display("FAIL exp_in_wait_issues: got ok=%b issues=%0d expected 1 3", ok, iss_q.size());
        else passed++;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] w[$];
        bit ok;
        clear_obs();
        exp_in  = 32'h5A5A5A5A;
        exp_vld = 1'b1;
        send_sum(32'h12345678);
        exp_vld = 1'b0;
        wait_done(400, ok);
        total++;
        if (!ok || iss_q.size() != 1 || q_q.size() != 1 || iss_q[0] !== 32'h5A5A5A5A)
            $display("FAIL simul_empty: got ok=%b issues=%0d expected 1 1 of 5a5a5a5a", ok, iss_q.size());
        else passed++;
        tick();
        clear_obs();
        w = '{32'h01010101, 32'h02020202, 32'h03030303};
        write_exp(w[0]);
        write_exp(w[1]);
        exp_in  = w[2];
        exp_vld = 1'b1;
        send_sum(32'h87654321);
        exp_vld = 1'b0;
        wait_done(400, ok);
        total++;
        if (!ok || iss_q != w || q_q != w)
            $display("FAIL simul_append: got ok=%b issues=%0d expected 1 3", ok, iss_q.size());
        else passed++;
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] w[$];
        bit ok;
        clear_obs();
        for (int i = 0; i < DEPTH + 1; i++) w.push_back($urandom);
        foreach (w[i]) write_exp(w[i]);
        total++;
        if (count !== 5'(DEPTH) || overflow !== 1'b1)
            $display("FAIL overflow_load: got count=%0d ovf=%b expected %0d 1", count, overflow, DEPTH);
        else passed++;
        send_sum(32'h42000000);
        wait_done(2000, ok);
        total++;
        if (!ok || iss_q.size() != DEPTH || q_q.size() != DEPTH)
            $display("FAIL overflow_issues: got ok=%b issues=%0d expected 1 %0d", ok, iss_q.size(), DEPTH);
        else passed++;
        total++;
        if (iss_q.size() != DEPTH || iss_q[DEPTH-1] !== w[DEPTH-1] || overflow !== 1'b1)
            $display("FAIL overflow_last: got last=%h ovf=%b expected %h 1",
                     iss_q.size() > 0 ? iss_q[iss_q.size()-1] : 32'h0, overflow, w[DEPTH-1]);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[$] = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
        logic [31:0] w2[$] = '{32'h3E000000, 32'h3D000000};
        bit ok;
        clear_obs();
        foreach (w[i]) write_exp(w[i]);
        send_sum(32'h40A00000);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (q_q.size() == 2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!ok) $display("FAIL reset_mid_progress: got %0d quotients expected 2", q_q.size());
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (all_outs() !== '0) $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
        else passed++;
        tick(2);
        rst_n = 1'b1;
        tick();
        clear_obs();
        foreach (w2[i]) write_exp(w2[i]);
        send_sum(32'h3F000000);
        wait_done(400, ok);
        total++;
        if (!ok || iss_q != w2 || q_q != w2 || proto_err != 0)
            $display("FAIL reset_mid_next: got ok=%b issues=%0d q=%0d perr=%0d expected 1 2 2 0",
                     ok, iss_q.size(), q_q.size(), proto_err);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_early_strobe();
        test_empty_sum();
        test_exp_in_wait();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
